// File: rtl/servant_gpio_pkg.sv
// ============================================================================
// servant_gpio_pkg : register offsets and bus state encoding for servant_gpio_irq
// Rev 1.0
// ============================================================================
`default_nettype none

package servant_gpio_pkg;

  localparam logic [2:0] ADR_OUT     = 3'd0;
  localparam logic [2:0] ADR_DIR     = 3'd1;
  localparam logic [2:0] ADR_IN      = 3'd2;
  localparam logic [2:0] ADR_RISE_EN = 3'd3;
  localparam logic [2:0] ADR_FALL_EN = 3'd4;
  localparam logic [2:0] ADR_PEND    = 3'd5;

  typedef enum logic [0:0] {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

endpackage

`default_nettype wire

// File: rtl/servant_gpio_sync.sv
// ============================================================================
// servant_gpio_sync : multi-stage pin synchroniser with unmasked edge pulses
// Rev 1.0
// ============================================================================
`default_nettype none

module servant_gpio_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_d};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_q    = sync_q[SYNC_STAGES-1];
  assign o_rise = o_q & ~prev_q;
  assign o_fall = ~o_q & prev_q;

endmodule

`default_nettype wire

// File: rtl/servant_gpio_irq.sv
// ============================================================================
// servant_gpio_irq : Wishbone GPIO with per-pin direction and edge interrupts
// Rev 1.0
// ============================================================================
`default_nettype none

module servant_gpio_irq
  import servant_gpio_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter     RESET_STRATEGY = "MINI"
) (
  input  logic             i_wb_clk,
  input  logic             i_wb_rst,
  input  logic [2:0]       i_wb_adr,
  input  logic [31:0]      i_wb_dat,
  input  logic             i_wb_we,
  input  logic             i_wb_cyc,
  output logic [31:0]      o_wb_rdt,
  output logic             o_wb_ack,
  input  logic [WIDTH-1:0] i_gpio_in,
  output logic [WIDTH-1:0] o_gpio_out,
  output logic [WIDTH-1:0] o_gpio_oe,
  output logic             o_irq
);

  bus_state_e       state_q, state_d;
  logic [31:0]      rdt_q, rdt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] pend_q, pend_d;

  logic [WIDTH-1:0] w_in, w_rise, w_fall, w_wdat, w_w1c;
  logic [31:0]      w_rd_mux;
  logic             w_accept, w_wr;
  logic             unused_dat;

  servant_gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk  (i_wb_clk),
    .i_rst  (i_wb_rst),
    .i_d    (i_gpio_in),
    .o_q    (w_in),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign unused_dat = ^i_wb_dat;

  always_comb begin
    w_accept = i_wb_cyc && (state_q == BUS_IDLE);
    // A write coinciding with reset must never land in the register file.
    w_wr     = w_accept && i_wb_we && !i_wb_rst;
    w_wdat   = i_wb_dat[WIDTH-1:0];
    state_d  = w_accept ? BUS_ACK : BUS_IDLE;

    w_rd_mux = '0;
    case (i_wb_adr)
      ADR_OUT:     w_rd_mux[WIDTH-1:0] = out_q;
      ADR_DIR:     w_rd_mux[WIDTH-1:0] = dir_q;
      ADR_IN:      w_rd_mux[WIDTH-1:0] = w_in;
      ADR_RISE_EN: w_rd_mux[WIDTH-1:0] = rise_en_q;
      ADR_FALL_EN: w_rd_mux[WIDTH-1:0] = fall_en_q;
      ADR_PEND:    w_rd_mux[WIDTH-1:0] = pend_q;
      default:     w_rd_mux = '0;
    endcase
    rdt_d = w_accept ? w_rd_mux : rdt_q;

    out_d     = (w_wr && i_wb_adr == ADR_OUT)     ? w_wdat : out_q;
    dir_d     = (w_wr && i_wb_adr == ADR_DIR)     ? w_wdat : dir_q;
    rise_en_d = (w_wr && i_wb_adr == ADR_RISE_EN) ? w_wdat : rise_en_q;
    fall_en_d = (w_wr && i_wb_adr == ADR_FALL_EN) ? w_wdat : fall_en_q;
    w_w1c     = (w_wr && i_wb_adr == ADR_PEND)    ? w_wdat : '0;

    // New edge events take priority over a same-cycle clear.
    pend_d = (pend_q & ~w_w1c) | (w_rise & rise_en_q) | (w_fall & fall_en_q);
  end

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state_q   <= BUS_IDLE;
      rdt_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      rdt_q     <= rdt_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
    end
  end

  generate
    if (RESET_STRATEGY == "MINI") begin : g_reset_mini
      always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
          out_q <= '0;
          dir_q <= '0;
        end else begin
          out_q <= out_d;
          dir_q <= dir_d;
        end
      end
    end else begin : g_reset_none
      always_ff @(posedge i_wb_clk) begin
        out_q <= out_d;
        dir_q <= dir_d;
      end
    end
  endgenerate

  assign o_wb_ack   = (state_q == BUS_ACK);
  assign o_wb_rdt   = rdt_q;
  assign o_gpio_out = out_q;
  assign o_gpio_oe  = dir_q;
  assign o_irq      = |pend_q;

endmodule

`default_nettype wire

// File: tb/tb_servant_gpio_irq.sv
// ============================================================================
// tb_servant_gpio_irq : directed self-checking bench for servant_gpio_irq
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_servant_gpio_irq;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [2:0]       adr;
  logic [31:0]      dat;
  logic             we;
  logic             cyc;
  logic [31:0]      rdt;
  logic             ack;
  logic [WIDTH-1:0] gpio_in;
  logic [WIDTH-1:0] gpio_out;
  logic [WIDTH-1:0] gpio_oe;
  logic             irq;

  int tests  = 0;
  int failed = 0;

  servant_gpio_irq #(
    .WIDTH          (WIDTH),
    .SYNC_STAGES    (2),
    .RESET_STRATEGY ("MINI")
  ) dut (
    .i_wb_clk   (clk),
    .i_wb_rst   (rst),
    .i_wb_adr   (adr),
    .i_wb_dat   (dat),
    .i_wb_we    (we),
    .i_wb_cyc   (cyc),
    .o_wb_rdt   (rdt),
    .o_wb_ack   (ack),
    .i_gpio_in  (gpio_in),
    .o_gpio_out (gpio_out),
    .o_gpio_oe  (gpio_oe),
    .o_irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge, waits (bounded) for ack, checks one-cycle latency
  // and that ack drops the following cycle; returns at a negedge.
  task automatic wb_xfer(input logic [2:0] a, input logic [31:0] d, input logic w,
                         output logic [31:0] q);
    int n;
    adr = a; dat = d; we = w; cyc = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 8);
    check("ack_latency", n, 1);
    q = rdt;
    cyc = 1'b0; we = 1'b0;
    @(negedge clk);
    check("ack_pulse", {31'd0, ack}, 0);
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(a, d, 1'b1, q);
  endtask

  task automatic wb_read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] q;
    wb_xfer(a, 32'd0, 1'b0, q);
    check(tag, q, exp);
  endtask

  initial begin
    rst = 1'b1; adr = '0; dat = '0; we = 1'b0; cyc = 1'b0; gpio_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ack", {31'd0, ack}, 0);
    check("rst_oe", {24'd0, gpio_oe}, 0);
    check("rst_out", {24'd0, gpio_out}, 0);
    check("rst_irq", {31'd0, irq}, 0);
    check("rst_rdt", rdt, 0);

    for (int a = 0; a < 8; a++) wb_read_check("rst_read", 3'(a), 32'd0);

    // Output and direction registers
    wb_write(3'd0, 32'h0000_00A5);
    wb_write(3'd1, 32'h0000_000F);
    check("gpio_out", {24'd0, gpio_out}, 32'h0000_00A5);
    check("gpio_oe", {24'd0, gpio_oe}, 32'h0000_000F);
    wb_read_check("rd_out", 3'd0, 32'h0000_00A5);
    wb_read_check("rd_dir", 3'd1, 32'h0000_000F);
    wb_write(3'd1, 32'hFFFF_FFFF);
    wb_read_check("rd_dir_wide", 3'd1, 32'h0000_00FF);
    wb_write(3'd2, 32'h0000_0055);
    wb_write(3'd6, 32'h1234_5678);
    wb_read_check("rd_adr6", 3'd6, 32'd0);

    // Rising edge on pins 0 and 7, only pin 0 enabled
    wb_write(3'd3, 32'h0000_0001);
    gpio_in = 8'h81;
    @(negedge clk); check("irq_lat1", {31'd0, irq}, 0);
    @(negedge clk); check("irq_lat2", {31'd0, irq}, 0);
    @(negedge clk); check("irq_lat3", {31'd0, irq}, 1);
    wb_read_check("rd_in", 3'd2, 32'h0000_0081);
    wb_read_check("pend_rise", 3'd5, 32'h0000_0001);

    // Falling edge on pin 7, then write-1-to-clear
    wb_write(3'd4, 32'h0000_0080);
    gpio_in = 8'h01;
    repeat (4) @(negedge clk);
    wb_read_check("pend_both", 3'd5, 32'h0000_0081);
    wb_write(3'd5, 32'h0000_0001);
    wb_read_check("pend_clr0", 3'd5, 32'h0000_0080);
    check("irq_still", {31'd0, irq}, 1);
    wb_write(3'd5, 32'h0000_0080);
    check("irq_clr", {31'd0, irq}, 0);
    wb_read_check("pend_zero", 3'd5, 32'd0);

    // Clear of bit 0 on the same edge as a new pin-0 rising event
    gpio_in = 8'h00;
    repeat (4) @(negedge clk);
    wb_write(3'd5, 32'h0000_0001);
    wb_read_check("pend_quiet", 3'd5, 32'd0);
    gpio_in = 8'h01;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    adr = 3'd5; dat = 32'h0000_0001; we = 1'b1; cyc = 1'b1;
    @(negedge clk);
    check("race_ack", {31'd0, ack}, 1);
    cyc = 1'b0; we = 1'b0;
    check("race_irq", {31'd0, irq}, 1);
    @(negedge clk);
    wb_read_check("race_pend", 3'd5, 32'h0000_0001);

    // Reset asserted while a write to OUT is being accepted
    wb_write(3'd0, 32'd0);
    @(negedge clk);
    rst = 1'b1; adr = 3'd0; dat = 32'h0000_00FF; we = 1'b1; cyc = 1'b1;
    @(negedge clk);
    check("rst_mid_ack", {31'd0, ack}, 0);
    check("rst_mid_out", {24'd0, gpio_out}, 0);
    rst = 1'b0; cyc = 1'b0; we = 1'b0;
    @(negedge clk);
    check("rst_mid_irq", {31'd0, irq}, 0);
    wb_read_check("rst_mid_rd", 3'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
